input_buffer: RTL and testbench
===============================

INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 Parameter DATA_W, default 16: width in bits of one signed input word.
REQ-002 Parameter N_IN, default 64: words per output vector; legal range 2..1024.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 data_in  input  DATA_W signed: serial input word.
REQ-006 data_in_valid  input  1: data_in carries a word this cycle.
REQ-007 busy  input  1: downstream stall; while high no word is accepted.
REQ-008 invec_bus  output  N_IN*DATA_W signed: last completed vector, word i at bits [(i+1)*DATA_W-1 : i*DATA_W].
REQ-009 vector_done  output  1: one-cycle pulse, invec_bus holds a newly completed vector.

Function
REQ-010 A word SHALL be accepted on a rising edge iff data_in_valid=1 and busy=0 at that edge; otherwise data_in is ignored.
REQ-011 Accepted words SHALL be stored in arrival order; the k-th accepted word of a vector (k=0..N_IN-1) SHALL land at index k of invec_bus.
REQ-012 An internal write counter (0..N_IN-1) SHALL increment per accepted word and wrap to 0 on the N_IN-th word.
REQ-013 Words SHALL be collected in a staging store; invec_bus SHALL be a separate output register loaded only on the edge that accepts the N_IN-th word (that word placed directly at index N_IN-1).
REQ-014 vector_done SHALL be registered: high for exactly the one cycle following the accepting edge of the N_IN-th word, low otherwise.
REQ-015 invec_bus SHALL remain stable from completion until the next completion, including while the next vector's words are being accepted.
REQ-016 Back-to-back streaming SHALL be supported: a word accepted in the same cycle vector_done is high SHALL become index 0 of the next vector with no lost or duplicated words.
REQ-017 busy high with a partial vector SHALL freeze the counter and staging contents; collection resumes unchanged when busy falls.
REQ-018 Gaps (data_in_valid low) SHALL have no effect on state.
REQ-019 A partial vector SHALL never raise vector_done; it is retained until completed or reset.
REQ-020 Data SHALL be stored bit-exact; no arithmetic, saturation or sign manipulation.

Reset
REQ-021 rst high SHALL immediately clear counter, staging store, invec_bus (all zeros) and vector_done (0).
REQ-022 Reset mid-vector SHALL discard the partial vector; the first word accepted after release is index 0.

Configuration
REQ-023 With macro INPUT_BUFFER_FILL_COUNT_EN defined, an extra output fill_count (width $clog2(N_IN+1)) SHALL present the number of words currently in the staging store (0 after reset and after each completion); without it the port and logic SHALL not exist and behaviour is otherwise identical.

Structure
REQ-024 Package input_buffer_pkg SHALL hold default constants DATA_W_DEF=16, N_IN_DEF=64 and the signed word typedef.
REQ-025 The write counter/accept logic SHALL be a sub-module ibuf_wr_ctr (outputs index and wrap pulse); storage remains in input_buffer.

Verification (N_IN=8, DATA_W=16)
REQ-026 Reset then 8 single-cycle words 100..107 with gaps -> one vector_done pulse the cycle after word 8; invec_bus indices 0..7 = 100..107.
REQ-027 4 words 1000..1003, busy=1 for 7 cycles with data_in_valid=1, data 0xDEAD -> nothing accepted; after busy=0, 0xDEAD then 1004..1006 -> vector {1000..1003, 0xDEAD(-8531), 1004..1006}.
REQ-028 24 consecutive valid words (random), busy=0 -> exactly 3 pulses 8 cycles apart, each vector matches its 8 words in order, invec_bus stable between pulses.
REQ-029 5 words then rst pulse then 8 words 1..8 -> single vector 1..8, invec_bus 0 and vector_done 0 during reset.
REQ-030 3 words then idle 20 cycles -> no vector_done; fill_count=3 when INPUT_BUFFER_FILL_COUNT_EN defined.

Source files
------------

// File: rtl/input_buffer_pkg.sv
// input_buffer_pkg: default sizing constants and the signed word type
// shared by the input buffer and its write counter.
`default_nettype none

package input_buffer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int N_IN_DEF   = 64;

  typedef logic signed [DATA_W_DEF-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/ibuf_wr_ctr.sv
// ibuf_wr_ctr: qualifies incoming words against the stall and tracks the
// staging slot for each one, pulsing o_wrap on the last word of a vector.
`default_nettype none

module ibuf_wr_ctr
  import input_buffer_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int IDX_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_busy,
  output logic             o_accept,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_wrap
);

  logic [IDX_W-1:0] r_idx;
  logic             w_accept;
  logic             w_last;

  assign w_accept = i_valid & ~i_busy;
  assign w_last   = (r_idx == IDX_W'(N_IN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign o_accept = w_accept;
  assign o_idx    = r_idx;
  assign o_wrap   = w_accept & w_last;

endmodule

`default_nettype wire

// File: rtl/input_buffer.sv
// input_buffer: gathers N_IN serial signed words into a parallel vector.
// Optional fill_count output enabled by defining INPUT_BUFFER_FILL_COUNT_EN.
`default_nettype none

module input_buffer
  import input_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_IN   = N_IN_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [DATA_W-1:0]        data_in,
  input  logic                            data_in_valid,
  input  logic                            busy,
  output logic signed [N_IN*DATA_W-1:0]   invec_bus,
  output logic                            vector_done
`ifdef INPUT_BUFFER_FILL_COUNT_EN
  ,
  output logic [$clog2(N_IN+1)-1:0]       fill_count
`endif
);

  localparam int IDX_W = $clog2(N_IN);

  logic                       w_accept;
  logic                       w_wrap;
  logic [IDX_W-1:0]           w_idx;

  logic signed [DATA_W-1:0]      r_stage [N_IN];
  logic signed [N_IN*DATA_W-1:0] r_invec;
  logic                          r_done;

  ibuf_wr_ctr #(
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_wr_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (data_in_valid),
    .i_busy   (busy),
    .o_accept (w_accept),
    .o_idx    (w_idx),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        r_stage[i] <= '0;
      end
    end else if (w_accept) begin
      r_stage[w_idx] <= data_in;
    end
  end

  // The closing word bypasses staging so the vector is complete on its own edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_invec <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_wrap;
      if (w_wrap) begin
        for (int i = 0; i < N_IN - 1; i++) begin
          r_invec[i*DATA_W +: DATA_W] <= r_stage[i];
        end
        r_invec[(N_IN-1)*DATA_W +: DATA_W] <= data_in;
      end
    end
  end

  assign invec_bus   = r_invec;
  assign vector_done = r_done;

`ifdef INPUT_BUFFER_FILL_COUNT_EN
  assign fill_count = $clog2(N_IN+1)'(w_idx);
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_buffer.sv
// tb_input_buffer: directed self-checking bench for input_buffer (N_IN=8, DATA_W=16).
`default_nettype none

module tb_input_buffer;
  import input_buffer_pkg::*;

  localparam int N = 8;
  localparam int W = 16;

  logic                  clk;
  logic                  rst;
  logic signed [W-1:0]   data_in;
  logic                  data_in_valid;
  logic                  busy;
  logic signed [N*W-1:0] invec_bus;
  logic                  vector_done;
`ifdef INPUT_BUFFER_FILL_COUNT_EN
  logic [$clog2(N+1)-1:0] fill_count;
`endif

  int checks = 0;
  int errors = 0;

  input_buffer #(
    .DATA_W (W),
    .N_IN   (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .busy          (busy),
    .invec_bus     (invec_bus),
    .vector_done   (vector_done)
`ifdef INPUT_BUFFER_FILL_COUNT_EN
    ,
    .fill_count    (fill_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, return just after the rising edge.
  task automatic cyc(input logic v, input logic b, input logic [W-1:0] d);
    @(negedge clk);
    data_in       = d;
    data_in_valid = v;
    busy          = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_invec", invec_bus, '0);
    chk("rst_done", {127'd0, vector_done}, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [W-1:0]   words [24];
  logic [N*W-1:0] exp_vec;
  logic [N*W-1:0] prev_vec;

  initial begin
    rst = 1'b1; data_in = '0; data_in_valid = 1'b0; busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_invec", invec_bus, '0);
    chk("reset_done", {127'd0, vector_done}, '0);
    @(negedge clk);
    rst = 1'b0;

    // 100..107 with a gap after every word
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, 1'b0, W'(100 + k));
      chk("t1_done", {127'd0, vector_done}, (k == N-1) ? 128'd1 : 128'd0);
      exp_vec[k*W +: W] = W'(100 + k);
      cyc(1'b0, 1'b0, 16'h5555);
      chk("t1_gap_done", {127'd0, vector_done}, '0);
    end
    chk("t1_vec", invec_bus, exp_vec);

    // stall with valid high must accept nothing
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, W'(1000 + k));
      exp_vec[k*W +: W] = W'(1000 + k);
    end
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 1'b1, 16'hDEAD);
      chk("t2_busy_done", {127'd0, vector_done}, '0);
    end
    cyc(1'b1, 1'b0, 16'hDEAD);
    exp_vec[4*W +: W] = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, W'(1004 + k));
      exp_vec[(5+k)*W +: W] = W'(1004 + k);
    end
    chk("t2_done", {127'd0, vector_done}, 128'd1);
    chk("t2_vec", invec_bus, exp_vec);
    chk("t2_dead_signed", {{112{invec_bus[5*W-1]}}, invec_bus[4*W +: W]}, 128'($signed(-16'sd8531)));

    // 24 back-to-back words: three vectors, stable output between pulses
    for (int k = 0; k < 24; k++) words[k] = W'($urandom);
    prev_vec = invec_bus;
    for (int k = 0; k < 24; k++) begin
      cyc(1'b1, 1'b0, words[k]);
      chk("t3_done", {127'd0, vector_done}, (k % N == N-1) ? 128'd1 : 128'd0);
      if (k % N == N-1) begin
        for (int j = 0; j < N; j++) exp_vec[j*W +: W] = words[(k/N)*N + j];
        chk("t3_vec", invec_bus, exp_vec);
        prev_vec = exp_vec;
      end else begin
        chk("t3_stable", invec_bus, prev_vec);
      end
    end
    cyc(1'b0, 1'b0, '0);
    chk("t3_tail_done", {127'd0, vector_done}, '0);

    // partial vector discarded by reset
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, W'(500 + k));
    data_in_valid = 1'b0;
    do_reset();
`ifdef INPUT_BUFFER_FILL_COUNT_EN
    #1;
    chk("t4_fill_rst", 128'(fill_count), '0);
`endif
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, 1'b0, W'(k + 1));
      chk("t4_done", {127'd0, vector_done}, (k == N-1) ? 128'd1 : 128'd0);
      exp_vec[k*W +: W] = W'(k + 1);
    end
    chk("t4_vec", invec_bus, exp_vec);

    // partial vector never completes on its own
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, W'(70 + k));
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, '0);
      chk("t5_idle_done", {127'd0, vector_done}, '0);
    end
    chk("t5_vec_kept", invec_bus, exp_vec);
`ifdef INPUT_BUFFER_FILL_COUNT_EN
    chk("t5_fill", 128'(fill_count), 128'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
